uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Transmit serializer downstream of the UART TX load/holding register. On the rising edge of that stage's shifting flag it captures the held byte and emits one asynchronous serial frame on txd: start bit, 5–8 LSB-first data bits, optional parity, 1 or 2 stop bits. When the frame completes it pulses done, which clears the holding stage's shifting flag and sets its txready. Bit timing comes from an internal clock-enable divider.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2); counter width is clog2(CLKS_PER_BIT).

Ports:
clk  in  1  system clock
rstb  in  1  reset, asynchronous, active-low
start  in  1  shifting level from the holding stage; a frame begins on its rising edge
data_in  in  8  byte from the holding stage; sampled on the start edge
dbits  in  4  data bit count; 5..8 valid, sampled on the start edge
parity_en  in  1  1 = append parity bit; sampled on the start edge
parity_odd  in  1  1 = odd parity, 0 = even; sampled on the start edge
two_stop  in  1  1 = two stop bits; sampled on the start edge
txd  out  1  serial line, registered, idles high
done  out  1  one-cycle pulse at end of frame
busy  out  1  high from the frame start cycle through the done cycle

Behaviour:
- Reset: txd=1, done=0, busy=0, state=IDLE, all counters 0, start_q=0. Reset mid-frame aborts it immediately; txd returns to 1 asynchronously. No done is issued for the aborted frame.
- Edge detect: start_q <= start every cycle. start_rise = start & ~start_q.
- Accept: only in IDLE. start_rise in any other state is ignored; no queueing.
- Capture on accept: shift_reg <= data_in; nbits <= clamp(dbits, 5, 8), so <5 -> 5 and >8 -> 8; latch parity_en, parity_odd, two_stop. Input changes after capture do not affect the frame.
- Parity: computed over the nbits captured bits only. Bits above nbits are excluded. Parity bit = XOR(bits) ^ parity_odd.
- States:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA loops nbits times, LSB first, shift_reg shifts right each bit.
  - DATA -> PARITY if parity_en, else STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if two_stop, else IDLE.
  - STOP2 -> IDLE.
- Bit timing:
  - The bit counter resets to 0 on state entry. The state advances when the counter equals CLKS_PER_BIT-1.
  - Each bit holds txd for exactly CLKS_PER_BIT cycles.
  - txd goes to 0 on the clock edge after the accept edge, i.e. 1 cycle latency from start_rise.
  - txd values: START=0, DATA=shift_reg[0], PARITY=parity bit, STOPx=1.
- done:
  - Asserted for exactly 1 cycle, on the final cycle of the last stop bit.
  - busy deasserts the cycle after done.
- Frame length = (1 + nbits + parity_en + 1 + two_stop) * CLKS_PER_BIT cycles.
- Back-to-back frames:
  - The holding stage drops start in response to done, then reasserts it on its next load.
  - If start is still high on the return to IDLE, there is no rising edge and no new frame. A fresh 0->1 transition is required.
  - A start_rise arriving the same cycle the FSM enters IDLE is accepted on the following cycle only if start_q still shows the edge. It does not, so the start must deassert for at least 1 cycle between frames.
- busy=1 in all states except IDLE.

Decomposition:
- Shared uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - constants DBITS_MIN=5, DBITS_MAX=8
  - parity function over masked data
- One sub-module, uart_baud_counter: cycle counter with clear input and terminal-count output, parameterized by CLKS_PER_BIT. Instantiated once.
- The FSM, shift register and parity logic stay in uart_tx_serializer.

Test Plan:
1. CLKS_PER_BIT=4, data_in=8'hA5, dbits=8, no parity, 1 stop, pulse start -> txd sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses 1 cycle at cycle 40 after the first low. busy high for 40 cycles.
2. data_in=8'h03, dbits=7, parity_en=1, parity_odd=0, two_stop=1 -> data bits 1,1,0,0,0,0,0, then parity 0, then stop 1,1. Frame is 11 bits = 44 cycles.
3. Same as scenario 2 with parity_odd=1 -> parity bit 1. Separately, dbits=4'd3 -> 5 data bits sent; dbits=4'd15 -> 8 data bits sent.
4. Mid-frame: toggle start, change data_in and dbits during DATA -> frame is unchanged, no second frame starts, exactly 1 done pulse.
5. Assert rstb=0 during the DATA state -> txd=1, busy=0 immediately. done is never asserted. A new start after release gives a clean full frame.
6. Hold start high continuously across done -> no second frame. Drop start for 1 cycle and raise it again -> second frame begins 1 cycle later.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } tx_state_e;

    localparam int unsigned DBITS_MIN = 5;
    localparam int unsigned DBITS_MAX = 8;

    function automatic logic [3:0] clamp_dbits(input logic [3:0] dbits);
        if (dbits < 4'(DBITS_MIN)) begin
            return 4'(DBITS_MIN);
        end else if (dbits > 4'(DBITS_MAX)) begin
            return 4'(DBITS_MAX);
        end
        return dbits;
    endfunction

    // nbits must already be clamped to 5..8; bits at and above nbits are ignored.
    function automatic logic masked_parity(input logic [7:0] data, input logic [3:0] nbits);
        logic [7:0] mask;
        mask = 8'hFF >> (4'd8 - nbits);
        return ^(data & mask);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; clr holds it at zero, tc flags the last cycle of a bit.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rstb,
    input  logic clr,
    output logic tc
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] Last = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == Last);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, 5-8 LSB-first data bits, optional parity, 1 or 2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic [3:0] dbits,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       two_stop,
    output logic       txd,
    output logic       done,
    output logic       busy
);

    tx_state_e  state_q, state_d;
    logic       start_q;
    logic [7:0] shift_q, shift_d;
    logic [3:0] nbits_q, nbits_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       two_stop_q, two_stop_d;
    logic       txd_q, txd_d;
    logic       start_rise;
    logic       tc;
    logic [3:0] dbits_clamped;

    assign start_rise    = start & ~start_q;
    assign dbits_clamped = clamp_dbits(dbits);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rstb(rstb),
        .clr (state_q == StIdle),
        .tc  (tc)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        bit_idx_d  = bit_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        done       = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d    = StStart;
                    shift_d    = data_in;
                    nbits_d    = dbits_clamped;
                    bit_idx_d  = '0;
                    par_en_d   = parity_en;
                    par_bit_d  = masked_parity(data_in, dbits_clamped) ^ parity_odd;
                    two_stop_d = two_stop;
                end
            end
            StStart: begin
                if (tc) state_d = StData;
            end
            StData: begin
                if (tc) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        state_d = par_en_q ? StParity : StStop1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (tc) state_d = StStop1;
            end
            StStop1: begin
                if (tc) begin
                    if (two_stop_q) begin
                        state_d = StStop2;
                    end else begin
                        state_d = StIdle;
                        done    = 1'b1;
                    end
                end
            end
            StStop2: begin
                if (tc) begin
                    state_d = StIdle;
                    done    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // txd is registered, so it follows the state being entered.
        case (state_d)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
            StParity: txd_d = par_bit_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            shift_q    <= '0;
            nbits_q    <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor checks the serial line.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk;
    logic       rstb;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] dbits;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       txd;
    logic       done;
    logic       busy;

    typedef struct {
        int          len;
        logic [11:0] bits;
    } frame_t;

    frame_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Monitor state
    bit     in_frame   = 0;
    bit     after_done = 0;
    int     cyc        = 0;
    int     frames_seen = 0;
    frame_t cur;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .start     (start),
        .data_in   (data_in),
        .dbits     (dbits),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .two_stop  (two_stop),
        .txd       (txd),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: the line as a list of bit values, built from the frame rules.
    function automatic frame_t model(input logic [7:0] d, input logic [3:0] db, input bit pe,
                                     input bit po, input bit ts);
        frame_t f;
        bit     q[$];
        int     n;
        int     ones;
        n    = (db < 5) ? 5 : ((db > 8) ? 8 : int'(db));
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) q.push_back(((ones % 2) == 1) ^ po);
        q.push_back(1'b1);
        if (ts) q.push_back(1'b1);
        f.len  = q.size();
        f.bits = '0;
        for (int i = 0; i < q.size(); i++) f.bits[i] = q[i];
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rstb) begin
            check(txd === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_outputs",
                  int'({txd, busy, done}), 4);
            in_frame   = 0;
            after_done = 0;
        end else begin
            if (!in_frame) begin
                if (after_done) check(busy === 1'b0, "busy_after_done", int'(busy), 0);
                after_done = 0;
                if (busy === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", 1, 0);
                    end else begin
                        cur      = exp_q.pop_front();
                        in_frame = 1;
                        cyc      = 0;
                    end
                end else begin
                    check(txd === 1'b1, "idle_txd", int'(txd), 1);
                    check(done === 1'b0, "idle_done", int'(done), 0);
                end
            end
            if (in_frame) begin
                check(txd === cur.bits[cyc / CPB],
                      $sformatf("frame%0d_bit%0d_txd", frames_seen, cyc / CPB),
                      int'(txd), int'(cur.bits[cyc / CPB]));
                check(busy === 1'b1, "busy_in_frame", int'(busy), 1);
                check(done === (cyc == cur.len * CPB - 1),
                      $sformatf("frame%0d_done_cyc%0d", frames_seen, cyc),
                      int'(done), int'(cyc == cur.len * CPB - 1));
                cyc++;
                if (cyc == cur.len * CPB) begin
                    in_frame   = 0;
                    after_done = 1;
                    frames_seen++;
                end
            end
        end
    end

    // Caller is at posedge+1 with start low for at least one cycle.
    task automatic send(input logic [7:0] d, input logic [3:0] db, input bit pe, input bit po,
                        input bit ts, input bit hold);
        data_in    = d;
        dbits      = db;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        start      = 1'b1;
        exp_q.push_back(model(d, db, pe, po, ts));
        @(posedge clk);
        #1;
        check(txd === 1'b0 && busy === 1'b1, "start_latency", int'({txd, busy}), 1);
        data_in    = 8'($urandom);
        dbits      = 4'($urandom);
        parity_en  = 1'($urandom);
        parity_odd = 1'($urandom);
        two_stop   = 1'($urandom);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        check(seen, "done_timeout", int'(seen), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1, required 0");
        $fatal(1, "timeout");
    end

    initial begin
        rstb       = 1'b0;
        start      = 1'b0;
        data_in    = '0;
        dbits      = 4'd8;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed frames
        send(8'hA5, 4'd8, 0, 0, 0, 0); wait_done();
        send(8'h03, 4'd7, 1, 0, 1, 0); wait_done();
        send(8'h03, 4'd7, 1, 1, 1, 0); wait_done();
        send(8'hFF, 4'd3, 1, 0, 0, 0); wait_done();
        send(8'hFF, 4'd15, 1, 1, 0, 0); wait_done();
        send(8'h00, 4'd0, 0, 0, 1, 0); wait_done();

        // Input churn mid-frame must not disturb the frame or start another
        send(8'h3C, 4'd8, 1, 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        start   = 1'b1;
        data_in = 8'hC3;
        dbits   = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (10) @(posedge clk);
        #1;

        // Reset during DATA aborts the frame
        send(8'h5A, 4'd8, 1, 0, 1, 0);
        repeat (8) @(posedge clk);
        #1;
        rstb = 1'b0;
        #1;
        check(txd === 1'b1 && busy === 1'b0 && done === 1'b0, "async_abort",
              int'({txd, busy, done}), 4);
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
        @(posedge clk);
        #1;
        send(8'h96, 4'd6, 1, 1, 0, 0); wait_done();

        // start held high across done: no second frame until a fresh rising edge
        send(8'h81, 4'd8, 0, 0, 0, 1);
        wait_done();
        repeat (6) @(posedge clk);
        #1;
        check(busy === 1'b0, "held_start_no_frame", int'(busy), 0);
        start = 1'b0;
        @(posedge clk);
        #1;
        send(8'h7E, 4'd8, 1, 0, 0, 0); wait_done();

        // Randomized frames
        for (int k = 0; k < 14; k++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 1'($urandom), 0);
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (10) @(posedge clk);
        #1;
        check(exp_q.size() == 0 && !in_frame, "scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
